run_ctrl: RTL and testbench

Synthesizable run controller that sequences one program run of the TopLevel core.
- Optionally clears data memory, then preloads it from a load stream.
- Releases the core's start (hold) line and waits for halt, with a cycle watchdog.
- Streams a configurable data-memory window out as results.
- Sits between a host/BIST port and the core's data_mem write/read port plus its start/halt pins.

---
 rtl/run_ctrl_pkg.sv | 17 +
 rtl/run_watchdog.sv | 30 +++
 rtl/run_ctrl.sv | 155 +++++++++++++++
 tb/tb_run_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run controller.
package run_ctrl_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      DUMP  = 3'd4,
      DONE  = 3'd5
   } run_state_e;

endpackage

// File: rtl/run_watchdog.sv
// Saturating run-cycle counter with a limit compare against the value it is about to take.
module run_watchdog #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] lim,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   logic [CNT_W-1:0] count_inc;

   assign count_inc = (&count) ? count : count + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count_inc;
   end

   // Comparing the incremented value lets the run end on exactly lim cycles.
   assign expired = en && (lim != '0) && (count_inc == lim);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: clear/preload data memory, run the core under a watchdog, dump a window.
//
// state | meaning
// IDLE  | waiting for go after reset
// CLEAR | zeroing data memory, one word per cycle
// LOAD  | writing load-stream entries until ld_last
// RUN   | core released, counting cycles until halt or timeout
// DUMP  | streaming the result window to the consumer
// DONE  | results valid, waiting for the next go
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CLR_MEM = 1,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              go,
   input  logic [CNT_W-1:0]  timeout_lim,
   input  logic [ADDR_W-1:0] dump_base,
   input  logic [ADDR_W:0]   dump_len,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              dut_start,
   input  logic              dut_halt,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              busy,
   output logic              done,
   output logic              timed_out,
   output logic [CNT_W-1:0]  run_cycles
);

   run_state_e        state, state_nx;
   logic [ADDR_W:0]   idx, idx_nx;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   len_q;
   logic              capture, set_to;
   logic              wd_clr, wd_en, wd_exp;

   run_watchdog #(.CNT_W(CNT_W)) u_watchdog (
      .clk     (CLK),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .lim     (timeout_lim),
      .count   (run_cycles),
      .expired (wd_exp)
   );

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         base_q    <= '0;
         len_q     <= '0;
         timed_out <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (capture) begin
            base_q    <= dump_base;
            len_q     <= dump_len;
            timed_out <= 1'b0;
         end else if (set_to) begin
            timed_out <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      capture    = 1'b0;
      set_to     = 1'b0;
      wd_clr     = 1'b0;
      wd_en      = 1'b0;
      ld_ready   = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      dut_start  = 1'b1;
      dump_valid = 1'b0;
      dump_addr  = '0;
      dump_data  = '0;
      case (state)
         IDLE, DONE: begin
            if (go) begin
               capture  = 1'b1;
               wd_clr   = 1'b1;
               idx_nx   = '0;
               state_nx = (CLR_MEM != 0) ? CLEAR : LOAD;
            end
         end
         CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = idx[ADDR_W-1:0];
            if (&idx[ADDR_W-1:0]) begin
               idx_nx   = '0;
               state_nx = LOAD;
            end else begin
               idx_nx = idx + (ADDR_W+1)'(1);
            end
         end
         LOAD: begin
            ld_ready  = 1'b1;
            mem_we    = ld_valid;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
            if (ld_valid && ld_last)
               state_nx = RUN;
         end
         RUN: begin
            dut_start = 1'b0;
            wd_en     = 1'b1;
            idx_nx    = '0;
            // run_cycles is still zero in the first RUN cycle, masking a stale halt.
            if (dut_halt && (run_cycles != '0)) begin
               state_nx = (len_q == '0) ? DONE : DUMP;
            end else if (wd_exp) begin
               set_to   = 1'b1;
               state_nx = (len_q == '0) ? DONE : DUMP;
            end
         end
         DUMP: begin
            mem_addr   = base_q + idx[ADDR_W-1:0];
            dump_valid = 1'b1;
            dump_addr  = base_q + idx[ADDR_W-1:0];
            dump_data  = mem_rdata;
            if (dump_ready) begin
               if (idx == len_q - (ADDR_W+1)'(1))
                  state_nx = DONE;
               else
                  idx_nx = idx + (ADDR_W+1)'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a memory model, a halting-core model and a dump scoreboard.
module tb_run_ctrl;

   logic        CLK = 1'b0;
   logic        rst_n;
   logic        go;
   logic [15:0] timeout_lim;
   logic [7:0]  dump_base;
   logic [8:0]  dump_len;
   logic        ld_valid, ld_ready, ld_last;
   logic [7:0]  ld_addr, ld_data;
   logic        mem_we;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        dut_start, dut_halt;
   logic        dump_valid, dump_ready;
   logic [7:0]  dump_addr, dump_data;
   logic        busy, done, timed_out;
   logic [15:0] run_cycles;

   logic [7:0]  mem [256];
   logic [7:0]  exp_mem [256];
   logic [15:0] exp_q [$];
   int          core_cnt = 0;
   int          halt_at = 0;
   logic        halt_force = 1'b0;
   int          total = 0;
   int          bad = 0;

   always #5 CLK = ~CLK;

   run_ctrl dut (
      .CLK(CLK), .rst_n(rst_n), .go(go), .timeout_lim(timeout_lim),
      .dump_base(dump_base), .dump_len(dump_len),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
      .ld_data(ld_data), .ld_last(ld_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dut_start(dut_start), .dut_halt(dut_halt),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_addr(dump_addr), .dump_data(dump_data),
      .busy(busy), .done(done), .timed_out(timed_out), .run_cycles(run_cycles)
   );

   always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   // Core model: halts in its halt_at-th running cycle, or holds halt high when forced.
   always @(posedge CLK) core_cnt <= dut_start ? 0 : core_cnt + 1;
   assign dut_halt = halt_force || ((halt_at != 0) && !dut_start && (core_cnt >= halt_at - 1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_start"}, dut_start, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_to"}, timed_out, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_ldrdy"}, ld_ready, 0);
      chk({tag, "_dvalid"}, dump_valid, 0);
      chk({tag, "_rc"}, run_cycles, 0);
      chk({tag, "_maddr"}, mem_addr, 0);
      chk({tag, "_mwdata"}, mem_wdata, 0);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start(input logic [7:0] b, input logic [8:0] l, input logic [15:0] t);
      dump_base = b; dump_len = l; timeout_lim = t; go = 1'b1;
      tick();
      go = 1'b0;
      dump_base = ~b; dump_len = 9'd3;
      chk("busy_after_go", busy, 1);
      chk("clear_we", mem_we, 1);
      chk("clear_wdata", mem_wdata, 0);
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
      for (int i = 0; i < 600 && !ld_ready; i++) tick();
      chk("reach_load", ld_ready, 1);
   endtask

   task automatic load_entry(input logic [7:0] a, input logic [7:0] d, input logic last, input int gap);
      for (int g = 0; g < gap; g++) begin
         ld_valid = 1'b0; ld_addr = a ^ 8'hFF; ld_data = 8'hEE;
         @(negedge CLK);
         chk("gap_no_we", mem_we, 0);
         tick();
      end
      ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
      @(negedge CLK);
      chk("load_we", mem_we, 1);
      chk("load_addr", mem_addr, a);
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      exp_mem[a] = d;
   endtask

   task automatic push_expected(input logic [7:0] b, input int l);
      for (int i = 0; i < l; i++) begin
         logic [7:0] a;
         a = b + 8'(i);
         exp_q.push_back({a, exp_mem[a]});
      end
   endtask

   task automatic run_phase(input int exp_len, input int go_at);
      int n = 0;
      chk("run_entry_start", dut_start, 0);
      while (!dut_start && n < 5000) begin
         go = (n == go_at);
         tick();
         go = 1'b0;
         n++;
      end
      chk("run_len", n, exp_len);
   endtask

   task automatic dump_phase(input bit stall, input int exp_n);
      int got = 0;
      bit prev_hold = 0;
      logic [7:0] pa = 0, pd = 0;
      logic [15:0] e;
      for (int n = 0; n < 2000 && !done; n++) begin
         dump_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge CLK);
         if (dump_valid) begin
            if (prev_hold) begin
               chk("dump_addr_stable", dump_addr, pa);
               chk("dump_data_stable", dump_data, pd);
            end
            if (dump_ready) begin
               chk("dump_q_nonempty", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("dump_addr", dump_addr, e[15:8]);
                  chk("dump_data", dump_data, e[7:0]);
               end
               got++;
            end
            prev_hold = !dump_ready; pa = dump_addr; pd = dump_data;
         end else begin
            prev_hold = 0;
         end
         tick();
      end
      dump_ready = 1'b0;
      chk("dump_reached_done", done, 1);
      chk("dump_count", got, exp_n);
   endtask

   task automatic finish_checks(input logic exp_to, input logic [15:0] exp_rc);
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 0);
      chk("fin_start", dut_start, 1);
      chk("fin_dvalid", dump_valid, 0);
      chk("fin_timed_out", timed_out, exp_to);
      chk("fin_run_cycles", run_cycles, exp_rc);
   endtask

   task automatic async_reset(input string tag);
      @(negedge CLK);
      rst_n = 1'b0;
      #1;
      chk_reset(tag);
      #2;
      rst_n = 1'b1;
      exp_q.delete();
      tick();
   endtask

   task automatic scen1();
      halt_force = 1'b0; halt_at = 37;
      start(8'd0, 9'd7, 16'd0);
      load_entry(8'd0, 8'h00, 1'b0, 0);
      load_entry(8'd1, 8'h08, 1'b0, 0);
      load_entry(8'd2, 8'h01, 1'b1, 0);
      push_expected(8'd0, 7);
      run_phase(37, -1);
      dump_phase(1'b0, 7);
      finish_checks(1'b0, 16'd37);
   endtask

   initial begin
      rst_n = 1'b0; go = 1'b0; timeout_lim = '0; dump_base = '0; dump_len = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0; dump_ready = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      #3;
      chk_reset("por");
      #9;
      rst_n = 1'b1;
      tick();

      scen1();

      // watchdog expiry
      halt_at = 0;
      start(8'd6, 9'd3, 16'd20);
      load_entry(8'd7, 8'h77, 1'b1, 0);
      push_expected(8'd6, 3);
      run_phase(20, -1);
      dump_phase(1'b0, 3);
      finish_checks(1'b1, 16'd20);

      // wrapping dump window with random stalls
      halt_at = 5;
      start(8'd254, 9'd4, 16'd0);
      load_entry(8'd254, 8'hAA, 1'b0, 0);
      load_entry(8'd255, 8'hBB, 1'b0, 0);
      load_entry(8'd0, 8'hCC, 1'b0, 0);
      load_entry(8'd1, 8'hDD, 1'b1, 0);
      push_expected(8'd254, 4);
      run_phase(5, -1);
      dump_phase(1'b1, 4);
      finish_checks(1'b0, 16'd5);

      // load gaps, overwrite, and halt coinciding with timeout
      halt_at = 3;
      start(8'd4, 9'd6, 16'd3);
      load_entry(8'd5, 8'h11, 1'b0, 2);
      load_entry(8'd9, 8'h33, 1'b0, 1);
      load_entry(8'd5, 8'h22, 1'b1, 3);
      push_expected(8'd4, 6);
      run_phase(3, -1);
      dump_phase(1'b0, 6);
      finish_checks(1'b0, 16'd3);

      // stale halt, go during RUN, empty dump window
      halt_force = 1'b1; halt_at = 0;
      start(8'd0, 9'd0, 16'd0);
      load_entry(8'd0, 8'h05, 1'b1, 0);
      run_phase(2, 0);
      dump_phase(1'b0, 0);
      finish_checks(1'b0, 16'd2);
      halt_force = 1'b0;

      // reset mid-LOAD
      start(8'd0, 9'd7, 16'd0);
      load_entry(8'd3, 8'h44, 1'b0, 0);
      async_reset("rst_load");

      // reset mid-DUMP
      halt_at = 4;
      start(8'd0, 9'd7, 16'd0);
      load_entry(8'd3, 8'h44, 1'b1, 0);
      run_phase(4, -1);
      dump_ready = 1'b0;
      @(negedge CLK);
      chk("pre_rst_dvalid", dump_valid, 1);
      async_reset("rst_dump");

      scen1();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
